// File: rtl/usb_proto_ctrl_if.sv
// Handshake bundle between usb_proto_ctrl and the receiver, transmitter, FIFO and host-side logic.
// The controller uses the slave modport; the surrounding logic (or a bench) uses master.
interface usb_proto_ctrl_if;
    logic [2:0] rx_packet;
    logic       rx_transfer_active;
    logic       rx_data_ready;
    logic       rx_error;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       rx_enable;
    logic       tx_data_valid;
    logic [6:0] tx_data_size;
    logic [6:0] buffer_occupancy;
    logic       tx_start;
    logic [1:0] tx_packet;
    logic       d_mode;
    logic       rx_done;
    logic       tx_done;
    logic       timeout;
    logic       proto_error;
    logic       busy;

    modport slave (
        input  rx_packet, rx_transfer_active, rx_data_ready, rx_error,
               tx_transfer_active, tx_error, rx_enable, tx_data_valid,
               tx_data_size, buffer_occupancy,
        output tx_start, tx_packet, d_mode, rx_done, tx_done, timeout,
               proto_error, busy
    );

    modport master (
        output rx_packet, rx_transfer_active, rx_data_ready, rx_error,
               tx_transfer_active, tx_error, rx_enable, tx_data_valid,
               tx_data_size, buffer_occupancy,
        input  tx_start, tx_packet, d_mode, rx_done, tx_done, timeout,
               proto_error, busy
    );
endinterface

// File: rtl/usb_proto_ctrl.sv
// USB full-speed endpoint transaction controller: picks DATA/ACK/NAK responses,
// owns bus direction and the response timeout, and reports outcomes as one-cycle pulses.
//
// state     | meaning
// IDLE      | waiting for a token from the host
// OUT_WAIT  | OUT token seen, waiting for the host DATA packet
// SEND_HS   | one-cycle request for an ACK/NAK handshake
// SEND_DATA | one-cycle request for an IN DATA packet
// TX_BUSY   | transmitter owns the bus until its send ends
// ACK_WAIT  | our DATA was sent, waiting for the host ACK
module usb_proto_ctrl #(
    parameter int TIMEOUT = 150,
    parameter int TMR_W   = 8
) (
    input logic             clk,
    input logic             n_rst,
    usb_proto_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, OUT_WAIT, SEND_HS, SEND_DATA, TX_BUSY, ACK_WAIT
    } state_t;

    localparam logic [1:0] PKT_DATA = 2'd0;
    localparam logic [1:0] PKT_ACK  = 2'd1;
    localparam logic [1:0] PKT_NAK  = 2'd2;
    localparam logic [2:0] PID_OUT  = 3'd0;
    localparam logic [2:0] PID_IN   = 3'd1;
    localparam logic [2:0] PID_ACK  = 3'd2;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state, next_state;
    logic [TMR_W-1:0] timer;
    logic             rx_act_q, tx_act_q, eop_q, tx_seen;
    logic [1:0]       pkt_q, pkt_n;
    logic             rx_done_n, tx_done_n, timeout_n, perr_n;
    logic             tx_start_q, d_mode_q, busy_q;
    logic             rx_done_q, tx_done_q, timeout_q, perr_q;
    logic             eop_good, eop_usable, tx_fall, expired, timed, in_ready;

    assign eop_good   = eop_q & ~bus.rx_error;
    // A new packet already starting holds the wait states; only expiry may leave them.
    assign eop_usable = eop_q & ~bus.rx_transfer_active;
    assign tx_fall    = tx_act_q & ~bus.tx_transfer_active;
    assign expired    = (timer == TMR_LAST);
    assign timed      = (state == OUT_WAIT) || (state == TX_BUSY) || (state == ACK_WAIT);
    assign in_ready   = bus.tx_data_valid && (bus.buffer_occupancy == bus.tx_data_size);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_act_q <= 1'b0;
            tx_act_q <= 1'b0;
            eop_q    <= 1'b0;
            tx_seen  <= 1'b0;
        end else begin
            rx_act_q <= bus.rx_transfer_active;
            tx_act_q <= bus.tx_transfer_active;
            eop_q    <= rx_act_q & ~bus.rx_transfer_active;
            tx_seen  <= ((state == TX_BUSY) & tx_seen) | bus.tx_transfer_active;
        end
    end

    always_comb begin
        next_state = state;
        pkt_n      = pkt_q;
        rx_done_n  = 1'b0;
        tx_done_n  = 1'b0;
        timeout_n  = 1'b0;
        perr_n     = 1'b0;
        case (state)
            IDLE: begin
                if (eop_good && bus.rx_packet == PID_OUT) begin
                    next_state = OUT_WAIT;
                end else if (eop_good && bus.rx_packet == PID_IN) begin
                    next_state = in_ready ? SEND_DATA : SEND_HS;
                    pkt_n      = in_ready ? PKT_DATA : PKT_NAK;
                end
            end
            OUT_WAIT: begin
                if (eop_usable) begin
                    if (eop_good && bus.rx_data_ready) begin
                        next_state = SEND_HS;
                        pkt_n      = bus.rx_enable ? PKT_ACK : PKT_NAK;
                    end else begin
                        next_state = IDLE;
                        perr_n     = 1'b1;
                    end
                end else if (expired) begin
                    next_state = IDLE;
                    timeout_n  = 1'b1;
                end
            end
            SEND_HS, SEND_DATA: next_state = TX_BUSY;
            TX_BUSY: begin
                if (bus.tx_error) begin
                    next_state = IDLE;
                    perr_n     = 1'b1;
                end else if (tx_fall) begin
                    next_state = (pkt_q == PKT_DATA) ? ACK_WAIT : IDLE;
                    rx_done_n  = (pkt_q == PKT_ACK);
                end else if (expired && !tx_seen) begin
                    next_state = IDLE;
                    timeout_n  = 1'b1;
                end
            end
            ACK_WAIT: begin
                if (eop_usable) begin
                    next_state = IDLE;
                    tx_done_n  = eop_good && (bus.rx_packet == PID_ACK);
                    perr_n     = !(eop_good && (bus.rx_packet == PID_ACK));
                end else if (expired) begin
                    next_state = IDLE;
                    timeout_n  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= next_state;
            if (!timed || next_state != state) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_q      <= PKT_NAK;
            tx_start_q <= 1'b0;
            d_mode_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_done_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            timeout_q  <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            pkt_q      <= pkt_n;
            tx_start_q <= (next_state == SEND_HS) || (next_state == SEND_DATA);
            d_mode_q   <= (next_state == SEND_HS) || (next_state == SEND_DATA) ||
                          (next_state == TX_BUSY);
            busy_q     <= (next_state != IDLE);
            rx_done_q  <= rx_done_n;
            tx_done_q  <= tx_done_n;
            timeout_q  <= timeout_n;
            perr_q     <= perr_n;
        end
    end

    assign bus.tx_start    = tx_start_q;
    assign bus.tx_packet   = pkt_q;
    assign bus.d_mode      = d_mode_q;
    assign bus.busy        = busy_q;
    assign bus.rx_done     = rx_done_q;
    assign bus.tx_done     = tx_done_q;
    assign bus.timeout     = timeout_q;
    assign bus.proto_error = perr_q;
endmodule

// File: tb/tb_usb_proto_ctrl.sv
// Bench for usb_proto_ctrl: fixed transaction table, timing/reset sequences, then random
// transactions scored by an outcome-level model of the endpoint protocol.
module tb_usb_proto_ctrl;
    localparam int TIMEOUT = 150;
    localparam int TMR_W   = 8;
    localparam int NV      = 16;
    localparam int NRAND   = 40;

    typedef struct {
        int tok; int tok_err;
        int data_present; int data_err; int data_rdy;
        int rx_en; int dvalid; int size; int occ;
        int tx_mode; int resp; int delay;
        int e_start; int e_pkt; int e_rxd; int e_txd; int e_to; int e_perr;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    usb_proto_ctrl_if bus_if();

    usb_proto_ctrl #(.TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_start = 0, n_rxd = 0, n_txd = 0, n_to = 0, n_perr = 0, multi = 0;
    int start_pkt = 0, start_cyc = 0, to_cyc = 0, dm_fall_cyc = 0;
    int fall_cyc = 0, tx_fall_cyc = 0;
    logic dm_prev = 1'b0;
    vec_t tbl [NV];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_rst) begin
            if (bus_if.tx_start) begin
                n_start++;
                start_pkt = int'(bus_if.tx_packet);
                start_cyc = cyc;
            end
            if (bus_if.rx_done) n_rxd++;
            if (bus_if.tx_done) n_txd++;
            if (bus_if.timeout) begin
                n_to++;
                to_cyc = cyc;
            end
            if (bus_if.proto_error) n_perr++;
            if (dm_prev && !bus_if.d_mode) dm_fall_cyc = cyc;
            if (int'(bus_if.rx_done) + int'(bus_if.tx_done) + int'(bus_if.timeout) +
                int'(bus_if.proto_error) > 1) multi++;
        end
        dm_prev = bus_if.d_mode;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input int pid, input int err, input int rdy);
        bus_if.rx_packet = 3'(pid);
        bus_if.rx_transfer_active = 1'b1;
        idle(4);
        bus_if.rx_transfer_active = 1'b0;
        bus_if.rx_error = (err != 0);
        bus_if.rx_data_ready = (rdy != 0);
        fall_cyc = cyc;
        idle(2);
        bus_if.rx_error = 1'b0;
        bus_if.rx_data_ready = 1'b0;
        bus_if.rx_packet = 3'd7;
    endtask

    function automatic vec_t mk(input int tok, input int terr, input int dp, input int derr,
                                input int drdy, input int ren, input int dval, input int size,
                                input int occ, input int mode, input int resp, input int delay,
                                input int es, input int ep, input int erxd, input int etxd,
                                input int eto, input int eperr);
        vec_t v;
        v.tok = tok; v.tok_err = terr; v.data_present = dp; v.data_err = derr;
        v.data_rdy = drdy; v.rx_en = ren; v.dvalid = dval; v.size = size; v.occ = occ;
        v.tx_mode = mode; v.resp = resp; v.delay = delay;
        v.e_start = es; v.e_pkt = ep; v.e_rxd = erxd; v.e_txd = etxd;
        v.e_to = eto; v.e_perr = eperr;
        return v;
    endfunction

    // Outcome of a whole transaction, reasoned from the protocol rules rather than cycle by cycle.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        int pk = 2;
        int sends = 0;
        r.e_start = 0; r.e_pkt = 2; r.e_rxd = 0; r.e_txd = 0; r.e_to = 0; r.e_perr = 0;
        if (v.tok_err != 0) return r;
        if (v.tok == 1) begin
            sends = 1;
            pk = (v.dvalid != 0 && v.size == v.occ) ? 0 : 2;
        end else if (v.tok == 0) begin
            if (v.data_present == 0) begin
                r.e_to = 1;
                return r;
            end
            if (v.data_err != 0 || v.data_rdy == 0) begin
                r.e_perr = 1;
                return r;
            end
            sends = 1;
            pk = (v.rx_en != 0) ? 1 : 2;
        end
        if (sends == 0) return r;
        r.e_start = 1;
        r.e_pkt = pk;
        if (v.tx_mode == 1) r.e_perr = 1;
        else if (v.tx_mode == 2) r.e_to = 1;
        else if (pk == 1) r.e_rxd = 1;
        else if (pk == 0) begin
            if (v.resp == 2) r.e_txd = 1;
            else if (v.resp == 7) r.e_to = 1;
            else r.e_perr = 1;
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int b_start = n_start, b_rxd = n_rxd, b_txd = n_txd, b_to = n_to, b_perr = n_perr;
        int got = 0;
        int lat = 0;
        bus_if.rx_enable = (v.rx_en != 0);
        bus_if.tx_data_valid = (v.dvalid != 0);
        bus_if.tx_data_size = 7'(v.size);
        bus_if.buffer_occupancy = 7'(v.occ);
        send_pkt(v.tok, v.tok_err, 0);
        if (v.tok == 0 && v.tok_err == 0 && v.data_present != 0) begin
            idle(3);
            send_pkt(4, v.data_err, v.data_rdy);
        end
        for (int i = 0; i < 20; i++) begin
            if (n_start != b_start) begin
                got = 1;
                break;
            end
            idle(1);
        end
        if (got != 0) begin
            lat = start_cyc - fall_cyc;
            if (v.tx_mode == 0) begin
                idle(2);
                bus_if.tx_transfer_active = 1'b1;
                idle(8);
                bus_if.tx_transfer_active = 1'b0;
                tx_fall_cyc = cyc;
                idle(2);
                if (v.resp != 7) begin
                    idle(v.delay);
                    send_pkt(v.resp, 0, 0);
                end
            end else if (v.tx_mode == 1) begin
                idle(2);
                bus_if.tx_transfer_active = 1'b1;
                idle(3);
                bus_if.tx_error = 1'b1;
                idle(1);
                bus_if.tx_error = 1'b0;
                bus_if.tx_transfer_active = 1'b0;
                idle(2);
            end
        end
        for (int i = 0; i < 400; i++) begin
            if (!bus_if.busy) break;
            idle(1);
        end
        chk({tag, " back_to_idle"}, int'(bus_if.busy), 0);
        idle(3);
        chk({tag, " tx_start_count"}, n_start - b_start, v.e_start);
        if (v.e_start != 0 && got != 0) begin
            chk({tag, " tx_packet"}, start_pkt, v.e_pkt);
            chk({tag, " start_latency"}, lat, 2);
            if (v.tx_mode == 0) chk({tag, " d_mode_release"}, dm_fall_cyc - tx_fall_cyc, 1);
        end
        chk({tag, " rx_done"}, n_rxd - b_rxd, v.e_rxd);
        chk({tag, " tx_done"}, n_txd - b_txd, v.e_txd);
        chk({tag, " timeout"}, n_to - b_to, v.e_to);
        chk({tag, " proto_error"}, n_perr - b_perr, v.e_perr);
    endtask

    initial begin
        vec_t v;
        int b_sum;
        int r;
        //        tok terr dp derr drdy ren dval size occ mode resp dly | st pkt rxd txd to perr
        tbl[0]  = mk(0, 0, 1, 0, 1, 1, 0,  0,  0, 0, 7,  0, 1, 1, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 1, 0, 0,  0,  0, 0, 7,  0, 1, 2, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 1,  8,  8, 0, 2, 40, 1, 0, 0, 1, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 1,  8,  7, 0, 2,  5, 1, 2, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 7,  0, 0, 2, 0, 0, 1, 0);
        tbl[5]  = mk(0, 0, 1, 1, 1, 1, 0,  0,  0, 0, 7,  0, 0, 2, 0, 0, 0, 1);
        tbl[6]  = mk(0, 0, 1, 0, 0, 1, 0,  0,  0, 0, 7,  0, 0, 2, 0, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 1,  8,  8, 1, 7,  0, 1, 0, 0, 0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 2,  3, 1, 2, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 1,  0,  0, 0, 3, 10, 1, 0, 0, 0, 0, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 1, 64, 64, 0, 7,  0, 1, 0, 0, 0, 1, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 0, 1,  8,  8, 0, 7,  0, 0, 2, 0, 0, 0, 0);
        tbl[12] = mk(2, 0, 0, 0, 0, 0, 0,  0,  0, 0, 7,  0, 0, 2, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0,  5,  5, 2, 7,  0, 1, 2, 0, 0, 1, 0);
        tbl[14] = mk(0, 0, 1, 0, 1, 1, 0,  0,  0, 1, 7,  0, 1, 1, 0, 0, 0, 1);
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 1, 64, 64, 0, 4,  0, 1, 0, 0, 0, 0, 1);

        bus_if.rx_packet = 3'd7;
        bus_if.rx_transfer_active = 1'b0;
        bus_if.rx_data_ready = 1'b0;
        bus_if.rx_error = 1'b0;
        bus_if.tx_transfer_active = 1'b0;
        bus_if.tx_error = 1'b0;
        bus_if.rx_enable = 1'b0;
        bus_if.tx_data_valid = 1'b0;
        bus_if.tx_data_size = 7'd0;
        bus_if.buffer_occupancy = 7'd0;

        idle(3);
        chk("reset tx_start", int'(bus_if.tx_start), 0);
        chk("reset d_mode", int'(bus_if.d_mode), 0);
        chk("reset busy", int'(bus_if.busy), 0);
        chk("reset tx_packet", int'(bus_if.tx_packet), 2);
        chk("reset pulses", int'(bus_if.rx_done) + int'(bus_if.tx_done) +
            int'(bus_if.timeout) + int'(bus_if.proto_error), 0);
        n_rst = 1'b1;
        idle(3);
        chk("post-reset busy", int'(bus_if.busy), 0);

        for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // OUT with no data: timeout exactly TIMEOUT cycles after OUT_WAIT is entered.
        run_vec(tbl[4], "out_timeout");
        chk("out_timeout latency", to_cyc - fall_cyc, TIMEOUT + 2);

        // Reset in the middle of a send.
        b_sum = n_rxd + n_txd + n_to + n_perr;
        bus_if.tx_data_valid = 1'b1;
        bus_if.tx_data_size = 7'd8;
        bus_if.buffer_occupancy = 7'd8;
        send_pkt(1, 0, 0);
        idle(2);
        bus_if.tx_transfer_active = 1'b1;
        idle(2);
        chk("pre-reset d_mode", int'(bus_if.d_mode), 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async reset d_mode", int'(bus_if.d_mode), 0);
        chk("async reset busy", int'(bus_if.busy), 0);
        idle(2);
        bus_if.tx_transfer_active = 1'b0;
        n_rst = 1'b1;
        idle(3);
        chk("reset no pulses", n_rxd + n_txd + n_to + n_perr - b_sum, 0);
        run_vec(tbl[2], "after_reset_in");

        for (int k = 0; k < NRAND; k++) begin
            r = int'($urandom_range(0, 7));
            v.tok = (r < 2) ? 0 : (r < 5) ? 1 : (r == 5) ? 2 : (r == 6) ? 3 : 5;
            v.tok_err = ($urandom_range(0, 9) == 0) ? 1 : 0;
            v.data_present = ($urandom_range(0, 7) == 0) ? 0 : 1;
            v.data_err = ($urandom_range(0, 7) == 0) ? 1 : 0;
            v.data_rdy = ($urandom_range(0, 5) == 0) ? 0 : 1;
            v.rx_en = int'($urandom_range(0, 1));
            v.dvalid = ($urandom_range(0, 3) == 0) ? 0 : 1;
            v.size = int'($urandom_range(1, 63));
            r = int'($urandom_range(0, 3));
            v.occ = (r == 0) ? v.size - 1 : (r == 1) ? v.size + 1 : v.size;
            r = int'($urandom_range(0, 9));
            v.tx_mode = (r < 8) ? 0 : (r == 8) ? 1 : 2;
            r = int'($urandom_range(0, 7));
            v.resp = (r < 5) ? 2 : (r == 5) ? 3 : (r == 6) ? 4 : 7;
            v.delay = int'($urandom_range(0, 60));
            v = predict(v);
            run_vec(v, $sformatf("rand%0d", k));
        end

        chk("pulse exclusivity", multi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
